// File: rtl/l2sw_pkg.sv
// rtl/l2sw_pkg.sv - shared widths, port helpers and state encoding for the L2 learning table
package l2sw_pkg;

  localparam int MAC_W     = 48;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;
  localparam int GROUP_BIT = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AGE,
    ST_FLUSH,
    ST_SEARCH,
    ST_UPDATE,
    ST_RESP
  } state_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] port);
    port_onehot = NUM_PORTS'(1) << port;
  endfunction

endpackage

// File: rtl/mac_learn_table.sv
// rtl/mac_learn_table.sv - sequential-search MAC learning table with aging, flush and forwarding result
module mac_learn_table
  import l2sw_pkg::*;
#(
  parameter int ADDR_LEN = 3,
  parameter int AGE_MAX  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [MAC_W-1:0]     req_dst_mac,
  input  logic [MAC_W-1:0]     req_src_mac,
  input  logic [PORT_W-1:0]    req_src_port,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NUM_PORTS-1:0] rsp_port_mask,
  output logic                 rsp_hit,
  input  logic                 age_tick,
  input  logic                 flush
);

  localparam int                  N           = 1 << ADDR_LEN;
  localparam logic [1:0]          LP_AGE_MAX  = 2'(AGE_MAX);
  localparam logic [ADDR_LEN-1:0] LP_LAST_IDX = '1;

  state_t r_state;
  state_t w_next_state;

  logic                r_valid [N];
  logic [MAC_W-1:0]    r_mac   [N];
  logic [PORT_W-1:0]   r_port  [N];
  logic [1:0]          r_age   [N];
  logic [ADDR_LEN-1:0] r_victim;

  logic                r_tick_pend;
  logic                r_flush_pend;

  logic [MAC_W-1:0]    r_dst_mac;
  logic [MAC_W-1:0]    r_src_mac;
  logic [PORT_W-1:0]   r_src_port;
  logic [ADDR_LEN-1:0] r_idx;

  logic                r_dst_hit;
  logic [PORT_W-1:0]   r_dst_port;
  logic                r_src_hit;
  logic [ADDR_LEN-1:0] r_src_idx;
  logic                r_free_found;
  logic [ADDR_LEN-1:0] r_free_idx;

  logic                 r_rsp_valid;
  logic [NUM_PORTS-1:0] r_rsp_mask;
  logic                 r_rsp_hit;

  logic                 w_accept;
  logic                 w_entry_dst_match;
  logic                 w_entry_src_match;
  logic                 w_entry_free;
  logic [NUM_PORTS-1:0] w_mask;
  logic                 w_hit;
  logic                 w_learn_en;
  logic                 w_use_victim;
  logic [ADDR_LEN-1:0]  w_learn_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_flush_pend) begin
          w_next_state = ST_FLUSH;
        end else if (r_tick_pend) begin
          w_next_state = ST_AGE;
        end else if (req_valid) begin
          w_next_state = ST_SEARCH;
        end
      end
      ST_AGE:    w_next_state = ST_IDLE;
      ST_FLUSH:  w_next_state = ST_IDLE;
      ST_SEARCH: if (r_idx == LP_LAST_IDX) w_next_state = ST_UPDATE;
      ST_UPDATE: w_next_state = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (r_state == ST_IDLE) && !r_flush_pend && !r_tick_pend;
    rsp_valid     = r_rsp_valid;
    rsp_port_mask = r_rsp_mask;
    rsp_hit       = r_rsp_hit;
  end

  assign w_accept          = req_valid && req_ready;
  assign w_entry_dst_match = r_valid[r_idx] && (r_mac[r_idx] == r_dst_mac);
  assign w_entry_src_match = r_valid[r_idx] && (r_mac[r_idx] == r_src_mac);
  assign w_entry_free      = !r_valid[r_idx];

  // Group destinations and unknown unicast flood; a known destination behind the ingress port is filtered.
  always_comb begin
    w_mask = ~port_onehot(r_src_port);
    w_hit  = 1'b0;
    if (!r_dst_mac[GROUP_BIT] && r_dst_hit) begin
      w_hit  = 1'b1;
      w_mask = (r_dst_port == r_src_port) ? '0 : port_onehot(r_dst_port);
    end
  end

  assign w_learn_en   = (r_state == ST_UPDATE) && !r_src_mac[GROUP_BIT];
  assign w_use_victim = !r_src_hit && !r_free_found;
  assign w_learn_idx  = r_src_hit ? r_src_idx : (r_free_found ? r_free_idx : r_victim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i] <= 1'b0;
        r_mac[i]   <= '0;
        r_port[i]  <= '0;
        r_age[i]   <= '0;
      end
      r_victim     <= '0;
      r_tick_pend  <= 1'b0;
      r_flush_pend <= 1'b0;
      r_dst_mac    <= '0;
      r_src_mac    <= '0;
      r_src_port   <= '0;
      r_idx        <= '0;
      r_dst_hit    <= 1'b0;
      r_dst_port   <= '0;
      r_src_hit    <= 1'b0;
      r_src_idx    <= '0;
      r_free_found <= 1'b0;
      r_free_idx   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_mask   <= '0;
      r_rsp_hit    <= 1'b0;
    end else begin
      // A pulse arriving while its flag is already set, including the serving cycle, collapses.
      if (r_state == ST_AGE) begin
        r_tick_pend <= 1'b0;
      end else if (age_tick) begin
        r_tick_pend <= 1'b1;
      end
      if (r_state == ST_FLUSH) begin
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dst_mac    <= req_dst_mac;
            r_src_mac    <= req_src_mac;
            r_src_port   <= req_src_port;
            r_idx        <= '0;
            r_dst_hit    <= 1'b0;
            r_src_hit    <= 1'b0;
            r_free_found <= 1'b0;
          end
        end
        ST_AGE: begin
          for (int i = 0; i < N; i++) begin
            if (r_valid[i]) begin
              if (r_age[i] == LP_AGE_MAX) begin
                r_valid[i] <= 1'b0;
              end else begin
                r_age[i] <= r_age[i] + 2'd1;
              end
            end
          end
        end
        ST_FLUSH: begin
          for (int i = 0; i < N; i++) begin
            r_valid[i] <= 1'b0;
          end
          r_victim <= '0;
        end
        ST_SEARCH: begin
          if (w_entry_dst_match && !r_dst_hit) begin
            r_dst_hit  <= 1'b1;
            r_dst_port <= r_port[r_idx];
          end
          if (w_entry_src_match && !r_src_hit) begin
            r_src_hit <= 1'b1;
            r_src_idx <= r_idx;
          end
          if (w_entry_free && !r_free_found) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          r_idx <= r_idx + 1'b1;
        end
        ST_UPDATE: begin
          if (w_learn_en) begin
            r_valid[w_learn_idx] <= 1'b1;
            r_mac[w_learn_idx]   <= r_src_mac;
            r_port[w_learn_idx]  <= r_src_port;
            r_age[w_learn_idx]   <= '0;
            if (w_use_victim) begin
              r_victim <= r_victim + 1'b1;
            end
          end
          r_rsp_valid <= 1'b1;
          r_rsp_mask  <= w_mask;
          r_rsp_hit   <= w_hit;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_learn_table.sv
// tb/tb_mac_learn_table.sv - scoreboard bench for the MAC learning table
module tb_mac_learn_table;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [47:0] req_dst_mac;
  logic [47:0] req_src_mac;
  logic [1:0]  req_src_port;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_port_mask;
  logic        rsp_hit;
  logic        age_tick;
  logic        flush;

  typedef struct {
    logic [3:0] mask;
    logic       hit;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [47:0] M1    = 48'h02_00_00_00_00_01;
  localparam logic [47:0] M2    = 48'h02_00_00_00_00_02;
  localparam logic [47:0] M9    = 48'h02_00_00_00_00_09;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] GSRC  = 48'h01_00_5E_00_00_AA;

  logic [3:0] flood_mask [4];

  mac_learn_table dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dst_mac  (req_dst_mac),
    .req_src_mac  (req_src_mac),
    .req_src_port (req_src_port),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_port_mask(rsp_port_mask),
    .rsp_hit      (rsp_hit),
    .age_tick     (age_tick),
    .flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] tmac(input int i);
    return 48'h02_00_00_00_01_00 | 48'(i);
  endfunction

  task automatic do_req(input logic [47:0] dst, input logic [47:0] src, input logic [1:0] port,
                        input logic [3:0] mask, input logic hit, input int hold);
    int         cyc;
    exp_t       e;
    logic [3:0] held_mask;
    logic       held_hit;
    sb_q.push_back('{mask: mask, hit: hit});
    @(negedge clk);
    req_valid    = 1'b1;
    req_dst_mac  = dst;
    req_src_mac  = src;
    req_src_port = port;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("accept_timeout", 64'(cyc < 50), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_latency", 64'(cyc), 64'd10);
    held_mask = rsp_port_mask;
    held_hit  = rsp_hit;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_mask", 64'(rsp_port_mask), 64'(held_mask));
      check("hold_hit", 64'(rsp_hit), 64'(held_hit));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    e = sb_q.pop_front();
    check("rsp_mask", 64'(rsp_port_mask), 64'(e.mask));
    check("rsp_hit", 64'(rsp_hit), 64'(e.hit));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
  endtask

  task automatic pulse_tick(input int cycles);
    @(negedge clk);
    age_tick = 1'b1;
    repeat (cycles) @(negedge clk);
    age_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    flood_mask[0] = 4'b1110;
    flood_mask[1] = 4'b1101;
    flood_mask[2] = 4'b1011;
    flood_mask[3] = 4'b0111;
    rst = 1'b1;
    req_valid = 1'b0;
    req_dst_mac = '0;
    req_src_mac = '0;
    req_src_port = '0;
    rsp_ready = 1'b0;
    age_tick = 1'b0;
    flush = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_mask", 64'(rsp_port_mask), 64'd0);
    check("reset_rsp_hit", 64'(rsp_hit), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // learn then forward
    do_req(M2, M1, 2'd1, 4'b1101, 1'b0, 0);
    do_req(M1, M2, 2'd3, 4'b0010, 1'b1, 0);
    // broadcast and same-port filter
    do_req(BCAST, GSRC, 2'd0, 4'b1110, 1'b0, 0);
    do_req(M1, GSRC, 2'd1, 4'b0000, 1'b1, 0);
    // backpressure
    do_req(M2, GSRC, 2'd0, 4'b1000, 1'b1, 20);
    // station move: M1 relearned on port 2
    do_req(M2, M1, 2'd2, 4'b1000, 1'b1, 0);
    do_req(M1, GSRC, 2'd0, 4'b0100, 1'b1, 0);

    // aging: two back-to-back pulses count once
    pulse_flush();
    do_req(M1, GSRC, 2'd0, 4'b1110, 1'b0, 0);
    do_req(BCAST, M1, 2'd1, 4'b1101, 1'b0, 0);
    pulse_tick(2);
    pulse_tick(1);
    pulse_tick(1);
    do_req(M1, GSRC, 2'd0, 4'b0010, 1'b1, 0);
    pulse_tick(1);
    do_req(M1, GSRC, 2'd0, 4'b1110, 1'b0, 0);

    // table full and victim replacement
    pulse_flush();
    for (int i = 0; i < 9; i++) begin
      do_req(BCAST, tmac(i), 2'(i % 4), flood_mask[i % 4], 1'b0, 0);
    end
    do_req(tmac(0), GSRC, 2'd0, 4'b1110, 1'b0, 0);
    do_req(tmac(1), GSRC, 2'd0, 4'b0010, 1'b1, 0);
    do_req(tmac(8), GSRC, 2'd1, 4'b0001, 1'b1, 0);
    check("victim_ptr", 64'(dut.r_victim), 64'd1);

    // reset in the middle of a search
    @(negedge clk);
    req_valid    = 1'b1;
    req_dst_mac  = tmac(1);
    req_src_mac  = M9;
    req_src_port = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_ready", 64'(req_ready), 64'd1);
    repeat (12) @(negedge clk);
    check("midreset_no_rsp", 64'(rsp_valid), 64'd0);
    do_req(tmac(1), GSRC, 2'd0, 4'b1110, 1'b0, 0);
    do_req(M9, GSRC, 2'd3, 4'b0111, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
